volume_button_ctrl: RTL and testbench

- Front end for the volume register stage.
- Takes raw, bouncing, active-low push-button levels (board KEYs) for volume up and down and conditions them: synchronise, debounce, press-edge detect, hold-to-auto-repeat.
- Emits clean, mutually exclusive single-cycle Vol_up / Vol_down pulses that feed the volume register's inputs of the same name directly.

---
 rtl/vol_btn_pkg.sv | 22 ++
 rtl/button_debounce.sv | 48 ++++
 rtl/volume_button_ctrl.sv | 121 ++++++++++++
 tb/tb_volume_button_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vol_btn_pkg.sv
// rtl/vol_btn_pkg.sv - shared state encoding and timing constants for the volume button front end
package vol_btn_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    UP_DELAY    = 3'd1,
    UP_REPEAT   = 3'd2,
    DOWN_DELAY  = 3'd3,
    DOWN_REPEAT = 3'd4,
    LOCK        = 3'd5
  } vol_state_t;

  // 50 MHz board timing: 10 ms debounce, 500 ms first repeat, 100 ms repeat rate
  localparam int DEF_DEBOUNCE = 500000;
  localparam int DEF_DELAY    = 25000000;
  localparam int DEF_PERIOD   = 5000000;

  localparam int SIM_DEBOUNCE = 4;
  localparam int SIM_DELAY    = 20;
  localparam int SIM_PERIOD   = 8;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser plus debounce counter for one active-low key
module button_debounce
  import vol_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n,
  output logic pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle
  always_comb begin
    sync_d  = {sync_q[0], key_n};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_TERM) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign pressed = ~level_q;

endmodule

// File: rtl/volume_button_ctrl.sv
// rtl/volume_button_ctrl.sv - debounced volume keys to single-cycle Vol_up/Vol_down pulses with hold-to-repeat
module volume_button_ctrl
  import vol_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int REPEAT_DELAY    = DEF_DELAY,
  parameter int REPEAT_PERIOD   = DEF_PERIOD
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Key_up_n,
  input  logic Key_down_n,
  output logic Vol_up,
  output logic Vol_down
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_TERM  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_TERM = RW'(REPEAT_PERIOD - 1);

  logic       up_pressed, down_pressed;
  vol_state_t state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic       vol_up_q, vol_up_d;
  logic       vol_down_q, vol_down_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
    .Clk     (Clk),
    .Reset   (Reset),
    .key_n   (Key_up_n),
    .pressed (up_pressed)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
    .Clk     (Clk),
    .Reset   (Reset),
    .key_n   (Key_down_n),
    .pressed (down_pressed)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      rcnt_q     <= '0;
      vol_up_q   <= 1'b0;
      vol_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      vol_up_q   <= vol_up_d;
      vol_down_q <= vol_down_d;
    end
  end

  // Release of the own key wins over the other key being pressed in the same cycle
  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    vol_up_d   = 1'b0;
    vol_down_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        rcnt_d = '0;
        if (up_pressed && down_pressed) begin
          state_d = LOCK;
        end else if (up_pressed) begin
          state_d  = UP_DELAY;
          vol_up_d = 1'b1;
        end else if (down_pressed) begin
          state_d    = DOWN_DELAY;
          vol_down_d = 1'b1;
        end
      end
      UP_DELAY, UP_REPEAT: begin
        if (!up_pressed) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (down_pressed) begin
          state_d = LOCK;
          rcnt_d  = '0;
        end else if (rcnt_q == ((state_q == UP_DELAY) ? DELAY_TERM : PERIOD_TERM)) begin
          state_d  = UP_REPEAT;
          rcnt_d   = '0;
          vol_up_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      DOWN_DELAY, DOWN_REPEAT: begin
        if (!down_pressed) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (up_pressed) begin
          state_d = LOCK;
          rcnt_d  = '0;
        end else if (rcnt_q == ((state_q == DOWN_DELAY) ? DELAY_TERM : PERIOD_TERM)) begin
          state_d    = DOWN_REPEAT;
          rcnt_d     = '0;
          vol_down_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      LOCK: begin
        rcnt_d = '0;
        if (!up_pressed && !down_pressed) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  assign Vol_up   = vol_up_q;
  assign Vol_down = vol_down_q;

endmodule

// File: tb/tb_volume_button_ctrl.sv
// tb/tb_volume_button_ctrl.sv - self-checking bench for volume_button_ctrl against a behavioural key model
module tb_volume_button_ctrl;
  import vol_btn_pkg::*;

  localparam int D  = SIM_DEBOUNCE;
  localparam int RD = SIM_DELAY;
  localparam int RP = SIM_PERIOD;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Key_up_n = 1'b1;
  logic Key_down_n = 1'b1;
  logic Vol_up, Vol_down;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int up_times[$];
  int dn_times[$];

  volume_button_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Key_up_n  (Key_up_n),
    .Key_down_n(Key_down_n),
    .Vol_up    (Vol_up),
    .Vol_down  (Vol_down)
  );

  always #5 Clk = ~Clk;

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  initial forever begin
    @(negedge Clk);
    if (Vol_up === 1'b1) up_times.push_back(cyc);
    if (Vol_down === 1'b1) dn_times.push_back(cyc);
  end

  // Reference model: raw key history per edge since reset, press age in cycles
  bit raw_u[$];
  bit raw_d[$];
  int mk;
  bit deb_u, deb_d;
  int act;
  bit lock;
  int age;
  bit exp_up, exp_dn;
  bit pu, pd, own, other;

  // True when the last D synchronised samples all disagree with lvl
  function automatic bit settled(input bit q[$], input int k, input bit lvl);
    int idx;
    bit v;
    for (int j = 0; j < D; j++) begin
      idx = k - 2 - j;
      v = (idx >= 1) ? q[idx-1] : 1'b1;
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge Clk or negedge Reset);
    if (!Reset) begin
      mk = 0; raw_u.delete(); raw_d.delete();
      deb_u = 1'b1; deb_d = 1'b1; act = 0; lock = 1'b0; age = 0;
      exp_up = 1'b0; exp_dn = 1'b0;
    end else begin
      pu = !deb_u; pd = !deb_d;
      exp_up = 1'b0; exp_dn = 1'b0;
      mk++;
      raw_u.push_back(Key_up_n);
      raw_d.push_back(Key_down_n);
      if (lock) begin
        if (!pu && !pd) lock = 1'b0;
      end else if (act == 0) begin
        if (pu && pd) lock = 1'b1;
        else if (pu) begin act = 1; age = 0; exp_up = 1'b1; end
        else if (pd) begin act = 2; age = 0; exp_dn = 1'b1; end
      end else begin
        own   = (act == 1) ? pu : pd;
        other = (act == 1) ? pd : pu;
        if (!own) act = 0;
        else if (other) begin act = 0; lock = 1'b1; end
        else begin
          age++;
          if (age == RD || (age > RD && (age - RD) % RP == 0)) begin
            if (act == 1) exp_up = 1'b1; else exp_dn = 1'b1;
          end
        end
      end
      if (settled(raw_u, mk, deb_u)) deb_u = !deb_u;
      if (settled(raw_d, mk, deb_d)) deb_d = !deb_d;
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      tests++;
      if (Vol_up !== 1'b0 || Vol_down !== 1'b0) begin
        failed++;
        $display("FAIL reset_hold cyc=%0d got up=%b dn=%b expected 0/0", cyc, Vol_up, Vol_down);
      end
    end
    Reset = 1'b1;
    up_times.delete(); dn_times.delete();
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      tests++;
      if (Vol_up !== exp_up || Vol_down !== exp_dn) begin
        failed++;
        $display("FAIL reset_idle cyc=%0d got up=%b dn=%b expected up=%b dn=%b", cyc, Vol_up, Vol_down, exp_up, exp_dn);
      end
    end
    tests++;
    if (up_times.size() + dn_times.size() != 0) begin
      failed++;
      $display("FAIL reset_no_pulse got %0d pulses expected 0", up_times.size() + dn_times.size());
    end
  endtask

  task automatic test_single_press();
    int e0;
    e0 = cyc;
    up_times.delete(); dn_times.delete();
    for (int i = 0; i < 40; i++) begin
      Key_up_n = (i < 12) ? 1'b0 : 1'b1;
      @(negedge Clk);
      tests++;
      if (Vol_up !== exp_up || Vol_down !== exp_dn) begin
        failed++;
        $display("FAIL single_model cyc=%0d got up=%b dn=%b expected up=%b dn=%b", cyc, Vol_up, Vol_down, exp_up, exp_dn);
      end
    end
    tests++;
    if (up_times.size() != 1 || up_times[0] != e0 + 7 || dn_times.size() != 0) begin
      failed++;
      $display("FAIL single_timing got up_count=%0d first=%0d dn_count=%0d expected 1 at %0d and 0",
               up_times.size(), (up_times.size() > 0) ? up_times[0] : -1, dn_times.size(), e0 + 7);
    end
  endtask

  task automatic test_bounce();
    int e0;
    e0 = cyc;
    up_times.delete(); dn_times.delete();
    for (int i = 0; i < 60; i++) begin
      if (i < 12) Key_up_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      else Key_up_n = (i < 30) ? 1'b0 : 1'b1;
      @(negedge Clk);
      tests++;
      if (Vol_up !== exp_up || Vol_down !== exp_dn) begin
        failed++;
        $display("FAIL bounce_model cyc=%0d got up=%b dn=%b expected up=%b dn=%b", cyc, Vol_up, Vol_down, exp_up, exp_dn);
      end
    end
    tests++;
    if (up_times.size() != 1 || up_times[0] != e0 + 19) begin
      failed++;
      $display("FAIL bounce_timing got count=%0d first=%0d expected 1 at %0d",
               up_times.size(), (up_times.size() > 0) ? up_times[0] : -1, e0 + 19);
    end
    up_times.delete();
    for (int i = 0; i < 30; i++) begin
      Key_up_n = (i < 3) ? 1'b0 : 1'b1;
      @(negedge Clk);
    end
    tests++;
    if (up_times.size() != 0) begin
      failed++;
      $display("FAIL glitch_no_pulse got %0d pulses expected 0", up_times.size());
    end
  endtask

  task automatic test_hold_repeat();
    int e0;
    int exp_off[6] = '{7, 27, 35, 43, 51, 59};
    e0 = cyc;
    up_times.delete(); dn_times.delete();
    for (int i = 0; i < 80; i++) begin
      Key_down_n = (i < 60) ? 1'b0 : 1'b1;
      @(negedge Clk);
      tests++;
      if (Vol_up !== exp_up || Vol_down !== exp_dn) begin
        failed++;
        $display("FAIL repeat_model cyc=%0d got up=%b dn=%b expected up=%b dn=%b", cyc, Vol_up, Vol_down, exp_up, exp_dn);
      end
    end
    tests++;
    if (dn_times.size() != 6 || up_times.size() != 0) begin
      failed++;
      $display("FAIL repeat_count got dn=%0d up=%0d expected 6 and 0", dn_times.size(), up_times.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        tests++;
        if (dn_times[j] != e0 + exp_off[j]) begin
          failed++;
          $display("FAIL repeat_time%0d got %0d expected %0d", j, dn_times[j], e0 + exp_off[j]);
        end
      end
    end
  endtask

  task automatic test_lock();
    int e0;
    int exp_off[6] = '{7, 27, 35, 43, 51, 117};
    e0 = cyc;
    up_times.delete(); dn_times.delete();
    for (int i = 0; i < 160; i++) begin
      Key_up_n   = (i < 90 || (i >= 110 && i < 125)) ? 1'b0 : 1'b1;
      Key_down_n = (i >= 45 && i < 70) ? 1'b0 : 1'b1;
      @(negedge Clk);
      tests++;
      if (Vol_up !== exp_up || Vol_down !== exp_dn) begin
        failed++;
        $display("FAIL lock_model cyc=%0d got up=%b dn=%b expected up=%b dn=%b", cyc, Vol_up, Vol_down, exp_up, exp_dn);
      end
    end
    tests++;
    if (up_times.size() != 6 || dn_times.size() != 0) begin
      failed++;
      $display("FAIL lock_count got up=%0d dn=%0d expected 6 and 0", up_times.size(), dn_times.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        tests++;
        if (up_times[j] != e0 + exp_off[j]) begin
          failed++;
          $display("FAIL lock_time%0d got %0d expected %0d", j, up_times[j], e0 + exp_off[j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int r;
    for (int i = 0; i < 7; i++) begin
      Key_up_n = 1'b0;
      @(negedge Clk);
    end
    tests++;
    if (Vol_up !== 1'b1) begin
      failed++;
      $display("FAIL midreset_pre got up=%b expected 1", Vol_up);
    end
    #2 Reset = 1'b0;
    #1;
    tests++;
    if (Vol_up !== 1'b0 || Vol_down !== 1'b0) begin
      failed++;
      $display("FAIL midreset_async got up=%b dn=%b expected 0/0", Vol_up, Vol_down);
    end
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    r = cyc;
    up_times.delete(); dn_times.delete();
    for (int i = 0; i < 50; i++) begin
      Key_up_n = (i < 27) ? 1'b0 : 1'b1;
      @(negedge Clk);
      tests++;
      if (Vol_up !== exp_up || Vol_down !== exp_dn) begin
        failed++;
        $display("FAIL midreset_model cyc=%0d got up=%b dn=%b expected up=%b dn=%b", cyc, Vol_up, Vol_down, exp_up, exp_dn);
      end
    end
    tests++;
    if (up_times.size() != 2 || up_times[0] != r + 7 || up_times[1] != r + 27) begin
      failed++;
      $display("FAIL midreset_timing got count=%0d first=%0d expected 2 at %0d,%0d",
               up_times.size(), (up_times.size() > 0) ? up_times[0] : -1, r + 7, r + 27);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 1200; i++) begin
      if (hold == 0) begin
        Key_up_n   = 1'($urandom_range(0, 1));
        Key_down_n = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 40);
      end
      hold--;
      @(negedge Clk);
      tests++;
      if (Vol_up !== exp_up || Vol_down !== exp_dn || (Vol_up && Vol_down)) begin
        failed++;
        $display("FAIL random_model cyc=%0d got up=%b dn=%b expected up=%b dn=%b", cyc, Vol_up, Vol_down, exp_up, exp_dn);
      end
    end
    Key_up_n = 1'b1;
    Key_down_n = 1'b1;
    repeat (20) @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_hold_repeat();
    test_lock();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
